regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 69 ++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: two-write/two-read register file with x0 hardwired to zero,
// optional write-to-read forwarding and a sequenced whole-file clear.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic [DATA_WIDTH-1:0] rd1_data,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, stateNext;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic doneQ, lastStep, fwdOk;
  assign lastStep = (state == CLEAR) && (idx == LAST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      doneQ <= lastStep;
      idx   <= (state == IDLE && clear_req) ? ADDR_WIDTH'(1) :
               (state == CLEAR && !lastStep) ? idx + 1'b1 : idx;
    end
  always_comb
    stateNext = (state == IDLE) ? (clear_req ? CLEAR : IDLE) : (lastStep ? IDLE : CLEAR);
  always_comb begin
    clear_busy = (state == CLEAR);
    clear_done = doneQ;
  end
  // wr1 is assigned last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clear_busy) begin
      regs[idx] <= '0;
    end else begin
      if (wr0_en && wr0_addr != '0) regs[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != '0) regs[wr1_addr] <= wr1_data;
    end
  // forwarding is suppressed during reset and clear so reads show stored contents
  assign fwdOk = (BYPASS != 0) && rst && !clear_busy;
  always_comb begin
    rd0_data = (rd0_addr == '0) ? '0 :
               (fwdOk && wr1_en && wr1_addr == rd0_addr) ? wr1_data :
               (fwdOk && wr0_en && wr0_addr == rd0_addr) ? wr0_data : regs[rd0_addr];
    rd1_data = (rd1_addr == '0) ? '0 :
               (fwdOk && wr1_en && wr1_addr == rd1_addr) ? wr1_data :
               (fwdOk && wr0_en && wr0_addr == rd1_addr) ? wr0_data : regs[rd1_addr];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench driving three builds (bypass, no bypass,
// 8-entry) with shared stimulus against a behavioural register-file model.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr0En = 1'b0, wr1En = 1'b0, clearReq = 1'b0;
  logic [4:0] wr0Addr = '0, wr1Addr = '0, rd0Addr = '0, rd1Addr = '0;
  logic [31:0] wr0Data = '0, wr1Data = '0;
  wire [2:0][1:0][31:0] actRd;
  wire [2:0] actBusy, actDone;
  always #5 clk = ~clk;

  regfile_mp dutA (
    .clk(clk), .rst(rst),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .rd0_addr(rd0Addr), .rd1_addr(rd1Addr),
    .rd0_data(actRd[0][0]), .rd1_data(actRd[0][1]),
    .clear_req(clearReq), .clear_busy(actBusy[0]), .clear_done(actDone[0])
  );
  regfile_mp #(.BYPASS(0)) dutB (
    .clk(clk), .rst(rst),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .rd0_addr(rd0Addr), .rd1_addr(rd1Addr),
    .rd0_data(actRd[1][0]), .rd1_data(actRd[1][1]),
    .clear_req(clearReq), .clear_busy(actBusy[1]), .clear_done(actDone[1])
  );
  regfile_mp #(.ADDR_WIDTH(3)) dutC (
    .clk(clk), .rst(rst),
    .wr0_en(wr0En), .wr0_addr(wr0Addr[2:0]), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr[2:0]), .wr1_data(wr1Data),
    .rd0_addr(rd0Addr[2:0]), .rd1_addr(rd1Addr[2:0]),
    .rd0_data(actRd[2][0]), .rd1_data(actRd[2][1]),
    .clear_req(clearReq), .clear_busy(actBusy[2]), .clear_done(actDone[2])
  );

  typedef struct packed {
    logic [2:0][1:0][31:0] rd;
    logic [2:0] busy;
    logic [2:0] done;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // model 0 = 32-entry file (shared by dutA/dutB), model 1 = 8-entry file (dutC)
  logic [31:0] mem [2][32];
  int clrStep [2];
  bit doneM [2];

  function automatic int nOf(int m);
    return m == 1 ? 8 : 32;
  endfunction

  function automatic logic [31:0] modelRead(int m, bit byp, logic [4:0] a);
    int msk = nOf(m) - 1;
    int ai = int'(a) & msk;
    if (!rst || ai == 0) return 32'd0;
    if (byp && clrStep[m] == 0) begin
      if (wr1En && (int'(wr1Addr) & msk) == ai) return wr1Data;
      if (wr0En && (int'(wr0Addr) & msk) == ai) return wr0Data;
    end
    return mem[m][ai];
  endfunction

  task automatic modelEdge();
    for (int m = 0; m < 2; m++) begin
      int n = nOf(m);
      int a0 = int'(wr0Addr) & (n - 1);
      int a1 = int'(wr1Addr) & (n - 1);
      if (!rst) begin
        for (int i = 0; i < 32; i++) mem[m][i] = '0;
        clrStep[m] = 0;
        doneM[m] = 1'b0;
      end else begin
        bit dn = (clrStep[m] == n - 1);
        if (clrStep[m] != 0) begin
          mem[m][clrStep[m]] = '0;
          clrStep[m] = dn ? 0 : clrStep[m] + 1;
        end else begin
          if (wr0En && a0 != 0) mem[m][a0] = wr0Data;
          if (wr1En && a1 != 0) mem[m][a1] = wr1Data;
          if (clearReq) clrStep[m] = 1;
        end
        doneM[m] = dn;
      end
    end
  endtask

  task automatic drive(input bit r, input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic [4:0] r0a, input logic [4:0] r1a, input bit cr);
    exp_t e;
    rst = r; wr0En = w0e; wr0Addr = w0a; wr0Data = w0d;
    wr1En = w1e; wr1Addr = w1a; wr1Data = w1d;
    rd0Addr = r0a; rd1Addr = r1a; clearReq = cr;
    for (int k = 0; k < 3; k++) begin
      int m = (k == 2) ? 1 : 0;
      e.rd[k][0] = modelRead(m, k != 1, r0a);
      e.rd[k][1] = modelRead(m, k != 1, r1a);
      e.busy[k] = r && clrStep[m] != 0;
      e.done[k] = r && doneM[m];
    end
    q.push_back(e);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  function automatic logic [4:0] rndAddr();
    return $urandom_range(1) != 0 ? 5'($urandom_range(3)) : 5'($urandom);
  endfunction

  task automatic rnd(input int rstPct, input int clrPct, input bit wrOn);
    drive($urandom_range(99) >= rstPct, wrOn && $urandom_range(1) != 0, rndAddr(), $urandom,
          wrOn && $urandom_range(1) != 0, rndAddr(), $urandom,
          rndAddr(), rndAddr(), $urandom_range(99) < clrPct);
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (actRd[k][p] !== e.rd[k][p]) begin
            errors++;
            $display("FAIL rd%0d dut%0d t=%0t: got %h expected %h", p, k, $time, actRd[k][p], e.rd[k][p]);
          end
        end
        checks++;
        if (actBusy[k] !== e.busy[k]) begin
          errors++;
          $display("FAIL clear_busy dut%0d t=%0t: got %b expected %b", k, $time, actBusy[k], e.busy[k]);
        end
        checks++;
        if (actDone[k] !== e.done[k]) begin
          errors++;
          $display("FAIL clear_done dut%0d t=%0t: got %b expected %b", k, $time, actDone[k], e.done[k]);
        end
      end
    end

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 32; i++) mem[m][i] = '0;
      clrStep[m] = 0;
      doneM[m] = 1'b0;
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rnd(100, 50, 1'b1);
    drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd5, 5'd5, 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd5, 5'd0, 0);
    drive(1, 1, 5'd0, 32'h1234, 0, 5'd0, 0, 5'd0, 5'd5, 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0);
    drive(1, 1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 5'd3, 5'd7, 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd7, 5'd7, 0);
    drive(1, 1, 5'd3, 32'hA, 0, 5'd0, 0, 5'd3, 5'd7, 0);
    drive(1, 1, 5'd3, 32'hB, 0, 5'd0, 0, 5'd3, 5'd3, 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd3, 5'd3, 0);
    for (int i = 1; i < 32; i++)
      drive(1, 1, 5'(i), $urandom | 32'h1, 0, 5'd0, 0, 5'(i), rndAddr(), 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 5'd1, 1);
    for (int i = 0; i < 31; i++)
      drive(1, 1, rndAddr(), $urandom, 1, 5'd9, $urandom, 5'd9, 5'($urandom), $urandom_range(1) != 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 5'd31, 1);
    for (int i = 0; i < 40; i++) rnd(0, 0, 1'b0);
    for (int i = 1; i < 32; i++)
      drive(1, 1, 5'(i), $urandom | 32'h1, 1, 5'(31 - i), $urandom, rndAddr(), rndAddr(), 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd4, 5'd2, 1);
    for (int i = 0; i < 10; i++) rnd(0, 0, 1'b1);
    drive(0, 1, 5'd4, 32'h77, 0, 5'd0, 0, 5'd4, 5'd9, 1);
    drive(0, 0, 5'd0, 0, 1, 5'd2, 32'h99, 5'd2, 5'd31, 0);
    drive(1, 1, 5'd4, 32'h55, 0, 5'd0, 0, 5'd2, 5'd9, 0);
    drive(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd4, 5'd4, 0);
    for (int i = 0; i < 40; i++) rnd(0, 0, 1'b0);
    for (int i = 0; i < 3000; i++) rnd(1, 3, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
